// File: rtl/ddr_cmd_sequencer.sv
// DDR command sequencer: drains the read-address FIFO and the write-address /
// write-data FIFO pair, arbitrates reads against writes round-robin, issues one
// command at a time over valid/ready, and labels returned read beats with the
// owner of the oldest outstanding read.
//
// state | meaning
// IDLE  | sample FIFO heads, pick a command and latch it
// ISSUE | command presented, waiting for cmd_ready_i
module ddr_cmd_sequencer #(
  parameter int BURST_LEN = 4,
  parameter int MAX_RD    = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  output logic        raf_read_o,
  input  logic        raf_empty_ni,
  input  logic        raf_block_i,
  input  logic [1:0]  raf_owner_i,
  input  logic [14:0] raf_addr_i,
  output logic        waf_read_o,
  input  logic        waf_empty_ni,
  input  logic [14:0] waf_addr_i,
  output logic        wdf_read_o,
  input  logic [3:0]  wdf_bytes_i,
  input  logic [31:0] wdf_data_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic        cmd_write_o,
  output logic        cmd_burst_o,
  output logic [14:0] cmd_addr_o,
  output logic [3:0]  cmd_bytes_o,
  output logic [31:0] cmd_data_o,
  input  logic        ddr_rvalid_i,
  input  logic [31:0] ddr_rdata_i,
  output logic        rd_valid_o,
  output logic [1:0]  rd_owner_o,
  output logic        rd_last_o,
  output logic [31:0] rd_data_o,
  output logic        rd_err_o
);

  localparam int PTR_W = $clog2(MAX_RD);
  localparam int BC_W  = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state_q, state_d;
  logic        cmd_write_q, cmd_write_d;
  logic        cmd_burst_q, cmd_burst_d;
  logic [14:0] cmd_addr_q, cmd_addr_d;
  logic [3:0]  cmd_bytes_q, cmd_bytes_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic [1:0]  cmd_owner_q, cmd_owner_d;
  logic        last_wr_q, last_wr_d;
  logic        grant_wr;

  // Tag queue of outstanding reads; pointers carry one extra wrap bit.
  logic [2:0]       tag_mem [MAX_RD];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   tag_count;
  logic             tag_push, tag_pop, tag_nonempty;
  logic [1:0]       head_owner;
  logic             head_block;

  logic [BC_W-1:0]  beat_q, beat_d;
  logic             beat_last;
  logic             rd_valid_q, rd_valid_d;
  logic [1:0]       rd_owner_q, rd_owner_d;
  logic             rd_last_q, rd_last_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_err_q, rd_err_d;

  logic             rd_cand, wr_cand, handshake;

  assign tag_count    = wr_ptr_q - rd_ptr_q;
  assign tag_nonempty = (tag_count != '0);
  assign {head_owner, head_block} = tag_mem[rd_ptr_q[PTR_W-1:0]];

  assign rd_cand   = raf_empty_ni && (tag_count < (PTR_W+1)'(MAX_RD));
  assign wr_cand   = waf_empty_ni;
  assign handshake = (state_q == ISSUE) && cmd_ready_i;
  assign tag_push  = handshake && !cmd_write_q;

  assign beat_last = !head_block || (beat_q == BC_W'(BURST_LEN - 1));
  assign tag_pop   = ddr_rvalid_i && tag_nonempty && beat_last;

  assign raf_read_o  = handshake && !cmd_write_q;
  assign waf_read_o  = handshake && cmd_write_q;
  assign wdf_read_o  = waf_read_o;

  assign cmd_valid_o = (state_q == ISSUE);
  assign cmd_write_o = cmd_write_q;
  assign cmd_burst_o = cmd_burst_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_bytes_o = cmd_bytes_q;
  assign cmd_data_o  = cmd_data_q;

  assign rd_valid_o = rd_valid_q;
  assign rd_owner_o = rd_owner_q;
  assign rd_last_o  = rd_last_q;
  assign rd_data_o  = rd_data_q;
  assign rd_err_o   = rd_err_q;

  // Next state: arbitrate in IDLE and latch the winner, hold in ISSUE until accepted.
  always_comb begin
    state_d     = state_q;
    cmd_write_d = cmd_write_q;
    cmd_burst_d = cmd_burst_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_bytes_d = cmd_bytes_q;
    cmd_data_d  = cmd_data_q;
    cmd_owner_d = cmd_owner_q;
    last_wr_d   = last_wr_q;
    grant_wr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_cand || wr_cand) begin
          // With both pending, alternate away from the previous grant.
          grant_wr    = wr_cand && (!rd_cand || !last_wr_q);
          last_wr_d   = grant_wr;
          cmd_write_d = grant_wr;
          if (grant_wr) begin
            cmd_burst_d = 1'b0;
            cmd_addr_d  = waf_addr_i;
            cmd_bytes_d = wdf_bytes_i;
            cmd_data_d  = wdf_data_i;
            cmd_owner_d = 2'b00;
          end else begin
            cmd_burst_d = raf_block_i;
            cmd_addr_d  = raf_addr_i;
            cmd_bytes_d = 4'h0;
            cmd_data_d  = 32'h0;
            cmd_owner_d = raf_owner_i;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command-side registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cmd_write_q <= 1'b0;
      cmd_burst_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_bytes_q <= '0;
      cmd_data_q  <= '0;
      cmd_owner_q <= '0;
      last_wr_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_write_q <= cmd_write_d;
      cmd_burst_q <= cmd_burst_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_bytes_q <= cmd_bytes_d;
      cmd_data_q  <= cmd_data_d;
      cmd_owner_q <= cmd_owner_d;
      last_wr_q   <= last_wr_d;
    end
  end

  // Tag storage; validity comes from the pointers, so no reset is needed here.
  always_ff @(posedge clock_i) begin
    if (tag_push) tag_mem[wr_ptr_q[PTR_W-1:0]] <= {cmd_owner_q, cmd_burst_q};
  end

  // Tag queue pointers; reset discards anything still outstanding.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (tag_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tag_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Read return: label each beat with the head tag, count beats, flag orphans.
  always_comb begin
    beat_d     = beat_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    if (ddr_rvalid_i) begin
      if (tag_nonempty) begin
        rd_valid_d = 1'b1;
        rd_owner_d = head_owner;
        rd_last_d  = beat_last;
        rd_data_d  = ddr_rdata_i;
        beat_d     = beat_last ? '0 : beat_q + 1'b1;
      end else begin
        rd_err_d = 1'b1;
      end
    end
  end

  // Read-return registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      beat_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= '0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end
  end

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer with small FWFT FIFO models on the input side.
module tb_ddr_cmd_sequencer;

  logic        clk;
  logic        reset_i;
  logic        raf_read_o, raf_empty_ni, raf_block_i;
  logic [1:0]  raf_owner_i;
  logic [14:0] raf_addr_i;
  logic        waf_read_o, waf_empty_ni;
  logic [14:0] waf_addr_i;
  logic        wdf_read_o;
  logic [3:0]  wdf_bytes_i;
  logic [31:0] wdf_data_i;
  logic        cmd_valid_o, cmd_ready_i, cmd_write_o, cmd_burst_o;
  logic [14:0] cmd_addr_o;
  logic [3:0]  cmd_bytes_o;
  logic [31:0] cmd_data_o;
  logic        ddr_rvalid_i;
  logic [31:0] ddr_rdata_i;
  logic        rd_valid_o, rd_last_o, rd_err_o;
  logic [1:0]  rd_owner_o;
  logic [31:0] rd_data_o;

  ddr_cmd_sequencer #(.BURST_LEN(4), .MAX_RD(4)) dut (
    .clock_i(clk), .reset_i(reset_i),
    .raf_read_o(raf_read_o), .raf_empty_ni(raf_empty_ni), .raf_block_i(raf_block_i),
    .raf_owner_i(raf_owner_i), .raf_addr_i(raf_addr_i),
    .waf_read_o(waf_read_o), .waf_empty_ni(waf_empty_ni), .waf_addr_i(waf_addr_i),
    .wdf_read_o(wdf_read_o), .wdf_bytes_i(wdf_bytes_i), .wdf_data_i(wdf_data_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_write_o(cmd_write_o),
    .cmd_burst_o(cmd_burst_o), .cmd_addr_o(cmd_addr_o), .cmd_bytes_o(cmd_bytes_o),
    .cmd_data_o(cmd_data_o), .ddr_rvalid_i(ddr_rvalid_i), .ddr_rdata_i(ddr_rdata_i),
    .rd_valid_o(rd_valid_o), .rd_owner_o(rd_owner_o), .rd_last_o(rd_last_o),
    .rd_data_o(rd_data_o), .rd_err_o(rd_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: entries written by the stimulus, popped on the strobes.
  logic [14:0] raf_addr_m [32];
  logic        raf_blk_m  [32];
  logic [1:0]  raf_own_m  [32];
  logic [14:0] waf_addr_m [32];
  logic [3:0]  wdf_bytes_m[32];
  logic [31:0] wdf_data_m [32];
  logic [5:0]  raf_wr = '0, raf_rd = '0, waf_wr = '0, waf_rd = '0;

  assign raf_empty_ni = (raf_rd != raf_wr);
  assign raf_addr_i   = raf_addr_m[raf_rd[4:0]];
  assign raf_block_i  = raf_blk_m[raf_rd[4:0]];
  assign raf_owner_i  = raf_own_m[raf_rd[4:0]];
  assign waf_empty_ni = (waf_rd != waf_wr);
  assign waf_addr_i   = waf_addr_m[waf_rd[4:0]];
  assign wdf_bytes_i  = wdf_bytes_m[waf_rd[4:0]];
  assign wdf_data_i   = wdf_data_m[waf_rd[4:0]];

  int raf_pops = 0, waf_pops = 0, strobe_err = 0, cmd_cnt = 0;
  logic        log_write [64];
  logic [14:0] log_addr  [64];

  always @(posedge clk) begin
    if (raf_read_o) begin raf_rd <= raf_rd + 1'b1; raf_pops <= raf_pops + 1; end
    if (waf_read_o) begin waf_rd <= waf_rd + 1'b1; waf_pops <= waf_pops + 1; end
    if (waf_read_o != wdf_read_o) strobe_err <= strobe_err + 1;
    if (cmd_valid_o && cmd_ready_i) begin
      log_write[cmd_cnt[5:0]] <= cmd_write_o;
      log_addr[cmd_cnt[5:0]]  <= cmd_addr_o;
      cmd_cnt <= cmd_cnt + 1;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_raf(input logic [1:0] own, input logic blk, input logic [14:0] a);
    raf_own_m[raf_wr[4:0]]  = own;
    raf_blk_m[raf_wr[4:0]]  = blk;
    raf_addr_m[raf_wr[4:0]] = a;
    raf_wr = raf_wr + 1'b1;
  endtask

  task automatic push_waf(input logic [14:0] a, input logic [3:0] b, input logic [31:0] d);
    waf_addr_m[waf_wr[4:0]]  = a;
    wdf_bytes_m[waf_wr[4:0]] = b;
    wdf_data_m[waf_wr[4:0]]  = d;
    waf_wr = waf_wr + 1'b1;
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  int base_cnt, base_pops;
  logic [14:0] exp_addr [6];
  logic        exp_wr   [6];

  initial begin
    reset_i = 1'b1; cmd_ready_i = 1'b0; ddr_rvalid_i = 1'b0; ddr_rdata_i = '0;

    // Reset values
    @(negedge clk);
    check("rst_cmd_valid", cmd_valid_o, 0);
    check("rst_raf_read", raf_read_o, 0);
    check("rst_waf_read", waf_read_o, 0);
    check("rst_cmd_addr", cmd_addr_o, 0);
    check("rst_rd_valid", rd_valid_o, 0);
    check("rst_rd_err", rd_err_o, 0);
    reset_i = 1'b0;

    // Single read
    cmd_ready_i = 1'b1;
    base_pops = raf_pops;
    push_raf(2'b10, 1'b0, 15'd10);
    @(negedge clk);
    check("sr_valid", cmd_valid_o, 1);
    check("sr_write", cmd_write_o, 0);
    check("sr_burst", cmd_burst_o, 0);
    check("sr_addr", cmd_addr_o, 10);
    check("sr_bytes", cmd_bytes_o, 0);
    check("sr_pop", raf_read_o, 1);
    @(negedge clk);
    check("sr_valid_drop", cmd_valid_o, 0);
    check("sr_pop_count", raf_pops - base_pops, 1);
    ddr_rvalid_i = 1'b1; ddr_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    ddr_rvalid_i = 1'b0;
    check("sr_rd_valid", rd_valid_o, 1);
    check("sr_rd_owner", rd_owner_o, 2'b10);
    check("sr_rd_last", rd_last_o, 1);
    check("sr_rd_data", rd_data_o, 32'hDEADBEEF);
    @(negedge clk);
    check("sr_rd_valid_drop", rd_valid_o, 0);

    // Block read with 3 cycles of backpressure
    cmd_ready_i = 1'b0;
    base_pops = raf_pops;
    push_raf(2'b01, 1'b1, 15'd57);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("br_valid", cmd_valid_o, 1);
      check("br_addr", cmd_addr_o, 57);
      check("br_burst", cmd_burst_o, 1);
      check("br_no_pop", raf_read_o, 0);
      if (i < 3) @(negedge clk);
    end
    cmd_ready_i = 1'b1;
    #1;
    check("br_pop", raf_read_o, 1);
    @(negedge clk);
    check("br_valid_drop", cmd_valid_o, 0);
    check("br_pop_count", raf_pops - base_pops, 1);
    for (int b = 0; b < 4; b++) begin
      ddr_rvalid_i = 1'b1; ddr_rdata_i = 32'hA0 + b;
      @(negedge clk);
      check("br_rd_valid", rd_valid_o, 1);
      check("br_rd_owner", rd_owner_o, 2'b01);
      check("br_rd_last", rd_last_o, (b == 3) ? 1 : 0);
      check("br_rd_data", rd_data_o, 32'hA0 + b);
    end
    ddr_rvalid_i = 1'b0;
    @(negedge clk);
    check("br_rd_valid_drop", rd_valid_o, 0);

    // Write
    base_pops = waf_pops;
    push_waf(15'd5, 4'b0011, 32'h12345678);
    @(negedge clk);
    check("wr_valid", cmd_valid_o, 1);
    check("wr_write", cmd_write_o, 1);
    check("wr_burst", cmd_burst_o, 0);
    check("wr_addr", cmd_addr_o, 5);
    check("wr_bytes", cmd_bytes_o, 4'b0011);
    check("wr_data", cmd_data_o, 32'h12345678);
    check("wr_waf_pop", waf_read_o, 1);
    check("wr_wdf_pop", wdf_read_o, 1);
    check("wr_raf_pop", raf_read_o, 0);
    @(negedge clk);
    check("wr_valid_drop", cmd_valid_o, 0);
    check("wr_rd_valid", rd_valid_o, 0);
    check("wr_pop_count", waf_pops - base_pops, 1);

    // Orphan beat sets the sticky error
    ddr_rvalid_i = 1'b1; ddr_rdata_i = 32'h0BAD0BAD;
    @(negedge clk);
    ddr_rvalid_i = 1'b0;
    check("err_set", rd_err_o, 1);
    check("err_no_valid", rd_valid_o, 0);
    repeat (3) @(negedge clk);
    check("err_sticky", rd_err_o, 1);
    reset_i = 1'b1;
    #1;
    check("err_cleared", rd_err_o, 0);
    @(negedge clk);
    reset_i = 1'b0;

    // Arbitration from reset: R,W,R,W,R,W
    exp_addr[0] = 15'd100; exp_addr[1] = 15'd200; exp_addr[2] = 15'd101;
    exp_addr[3] = 15'd201; exp_addr[4] = 15'd102; exp_addr[5] = 15'd202;
    exp_wr[0] = 0; exp_wr[1] = 1; exp_wr[2] = 0; exp_wr[3] = 1; exp_wr[4] = 0; exp_wr[5] = 1;
    base_cnt = cmd_cnt;
    for (int i = 0; i < 3; i++) begin
      push_raf(2'b00, 1'b0, 15'(100 + i));
      push_waf(15'(200 + i), 4'hF, 32'(i));
    end
    repeat (16) @(negedge clk);
    check("arb_count", cmd_cnt - base_cnt, 6);
    for (int i = 0; i < 6; i++) begin
      check("arb_type", log_write[6'(base_cnt + i)], exp_wr[i]);
      check("arb_addr", log_addr[6'(base_cnt + i)], exp_addr[i]);
    end
    pulse_reset();

    // Tag limit: four reads outstanding block the fifth
    base_cnt = cmd_cnt;
    push_raf(2'b11, 1'b0, 15'd300);
    push_raf(2'b01, 1'b0, 15'd301);
    push_raf(2'b10, 1'b0, 15'd302);
    push_raf(2'b00, 1'b0, 15'd303);
    push_raf(2'b01, 1'b0, 15'd304);
    repeat (14) @(negedge clk);
    check("lim_count", cmd_cnt - base_cnt, 4);
    check("lim_blocked", cmd_valid_o, 0);
    ddr_rvalid_i = 1'b1; ddr_rdata_i = 32'h55;
    @(negedge clk);
    ddr_rvalid_i = 1'b0;
    check("lim_rd_valid", rd_valid_o, 1);
    check("lim_rd_owner", rd_owner_o, 2'b11);
    check("lim_still_blocked", cmd_valid_o, 0);
    @(negedge clk);
    check("lim_fifth_valid", cmd_valid_o, 1);
    check("lim_fifth_addr", cmd_addr_o, 304);
    @(negedge clk);
    pulse_reset();

    // Reset while a command is pending
    cmd_ready_i = 1'b0;
    base_pops = raf_pops;
    push_raf(2'b10, 1'b1, 15'd77);
    @(negedge clk);
    check("rsi_valid", cmd_valid_o, 1);
    check("rsi_addr", cmd_addr_o, 77);
    reset_i = 1'b1;
    #1;
    check("rsi_valid_clr", cmd_valid_o, 0);
    check("rsi_addr_clr", cmd_addr_o, 0);
    check("rsi_burst_clr", cmd_burst_o, 0);
    cmd_ready_i = 1'b1;
    #1;
    check("rsi_no_pop", raf_read_o, 0);
    repeat (2) @(negedge clk);
    check("rsi_pop_count", raf_pops - base_pops, 0);
    reset_i = 1'b0;
    @(negedge clk);
    check("rsi_reissue", cmd_valid_o, 1);
    check("rsi_reissue_addr", cmd_addr_o, 77);
    @(negedge clk);
    check("strobe_pairing", strobe_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_sequencer.md
# ddr_cmd_sequencer

Command sequencer directly downstream of the user request FIFOs in the DDR memory path. It drains the read-address FIFO (raf) and the write-address/write-data FIFO pair (waf/wdf), arbitrates between reads and writes, and issues one command at a time to the DDR controller over a valid/ready handshake. It tracks outstanding reads in a tag queue so returned read data is labelled with the requesting owner.

## Interface
Parameters:
- BURST_LEN, 4, number of data beats returned for a block read (`raf_block_i`=1); single reads return 1 beat.
- MAX_RD, 4, maximum outstanding reads; tag queue depth, power of two.

Ports:
- clock_i  in  1  system clock; all logic on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- raf_read_o  out  1  one-cycle pop strobe to the read-address FIFO.
- raf_empty_ni  in  1  read-address FIFO head valid, first-word fall-through.
- raf_block_i  in  1  head entry is a block (burst) read.
- raf_owner_i  in  2  head entry owner tag.
- raf_addr_i  in  15  head entry address.
- waf_read_o  out  1  pop strobe to the write-address FIFO.
- waf_empty_ni  in  1  write-address FIFO head valid; the wdf head is valid whenever this is high.
- waf_addr_i  in  15  write address.
- wdf_read_o  out  1  pop strobe to the write-data FIFO; always equal to `waf_read_o`.
- wdf_bytes_i  in  4  byte enables for the write word.
- wdf_data_i  in  32  write data word.
- cmd_valid_o  out  1  command valid to DDR controller.
- cmd_ready_i  in  1  controller accepts the command this cycle.
- cmd_write_o  out  1  1 = write, 0 = read.
- cmd_burst_o  out  1  1 = BURST_LEN-beat read.
- cmd_addr_o  out  15  command address.
- cmd_bytes_o  out  4  write byte enables (0 for reads).
- cmd_data_o  out  32  write data (0 for reads).
- ddr_rvalid_i  in  1  read data beat from controller.
- ddr_rdata_i  in  32  read data beat.
- rd_valid_o  out  1  read data valid to user side.
- rd_owner_o  out  2  owner of the current beat.
- rd_last_o  out  1  final beat of the read.
- rd_data_o  out  32  read data.
- rd_err_o  out  1  sticky: beat returned while no read was outstanding.

## Operation
- States: IDLE, ISSUE.
- IDLE: candidates are read (`raf_empty_ni`=1 and outstanding count < MAX_RD) and write (`waf_empty_ni`=1). Neither → stay. One → select it. Both → round-robin: grant the type opposite to the last grant. Latch the FIFO head into the cmd_* registers, assert `cmd_valid_o`, go to ISSUE.
- ISSUE: hold `cmd_valid_o` and all cmd_* fields stable until `cmd_ready_i`. In the handshake cycle: pulse the matching pop strobe(s) for exactly that cycle, push {owner, block} into the tag queue for reads, drop `cmd_valid_o` on the next edge, return to IDLE.
- Read return: each `ddr_rvalid_i` beat is assigned to the tag-queue head; a beat counter counts 1 or BURST_LEN beats. On the last beat, pop the tag and reset the counter.
- Outstanding count: push and pop in the same cycle leave it unchanged.
- `ddr_rvalid_i` with an empty tag queue: beat dropped, `rd_valid_o` not asserted, `rd_err_o` set until reset.
- Reset values: every output 0. State IDLE, tag queue empty, beat counter 0, last grant = write, so the first contended grant is a read.
- Reset mid-operation: pending command abandoned without a pop, outstanding tags discarded.

## Timing
- FIFO head to `cmd_valid_o`: 1 cycle, registered in IDLE.
- Ready already high: handshake in the first ISSUE cycle, so back-to-back commands are spaced 2 cycles apart.
- Pop strobe is combinational on (ISSUE & `cmd_ready_i`) and is never asserted outside a handshake.
- FIFO empty flags are sampled only in IDLE, which is at least one edge after any pop.
- Read data path: `rd_*` outputs are registered, 1 cycle after `ddr_rvalid_i`. Beats may be continuous with no bubbles.

## Test plan
- Single read: raf head {owner=2'b10, block=0, addr=10}, `cmd_ready_i`=1 → `cmd_valid_o` high 1 cycle with write=0, burst=0, addr=10, and `raf_read_o` pulses once. One `ddr_rvalid_i` beat 0xDEADBEEF → next cycle `rd_valid_o`=1, owner=2'b10, last=1, data=0xDEADBEEF.
- Block read plus backpressure: block=1, addr=57, `cmd_ready_i` low for 3 cycles → fields stable for 4 cycles and no pop until the handshake. Then 4 beats → `rd_last_o` only on the 4th beat.
- Write: waf addr=5, wdf bytes=4'b0011, data=0x12345678 → cmd write=1 with those values; `waf_read_o` and `wdf_read_o` pulse together, and `rd_valid_o` stays 0.
- Arbitration: both FIFOs loaded with 3 entries each from reset → command order R,W,R,W,R,W.
- Tag limit: MAX_RD=4 with no returns → exactly 4 reads issued, the 5th waits; one returned single beat → 5th issued 2 cycles later.
- Error and reset: `ddr_rvalid_i` with nothing outstanding → `rd_err_o`=1 and stays high. `reset_i` pulsed during ISSUE → all outputs 0 immediately and no pop issued.
